// File: rtl/decoder_pkg.sv
// Shared types for the decoder/scanner: FSM state encoding and mode constants.
package decoder_pkg;

  typedef enum logic {
    ST_DEC  = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  localparam logic MODE_DECODE = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/dwell_timer.sv
// Scan dwell countdown: loads a value, decrements to zero and waits there.
module dwell_timer #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  output logic               zero
);

  logic [DWELL_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      if (load)              cnt_d = load_val;
      else if (cnt_q != '0)  cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/decoder_scan_n.sv
// N-to-2**N one-hot decoder with an auto-scan mode that walks every output,
// holding each one for dwell+1 cycles.
module decoder_scan_n
  import decoder_pkg::*;
#(
  parameter int N       = 3,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic               in_valid,
  input  logic [N-1:0]       in_sel,
  input  logic [DWELL_W-1:0] dwell,
  output logic [(1<<N)-1:0]  Y,
  output logic [N-1:0]       idx,
  output logic               out_valid,
  output logic               wrap
);

  localparam int W = 1 << N;

  state_e         state_q, state_d;
  logic [W-1:0]   y_q, y_d;
  logic [N-1:0]   idx_q, idx_d;
  logic           out_valid_q, out_valid_d;
  logic           wrap_q, wrap_d;
  logic           tmr_en, tmr_load, tmr_zero;

  function automatic logic [W-1:0] onehot(input logic [N-1:0] s);
    onehot    = '0;
    onehot[s] = 1'b1;
  endfunction

  always_comb begin
    state_d     = state_q;
    y_d         = y_q;
    idx_d       = idx_q;
    out_valid_d = 1'b0;
    wrap_d      = 1'b0;
    tmr_en      = 1'b0;
    tmr_load    = 1'b0;
    if (en) begin
      case (state_q)
        ST_DEC: begin
          // Scan request outranks a same-cycle decode request.
          if (mode == MODE_SCAN) begin
            state_d     = ST_SCAN;
            idx_d       = '0;
            y_d         = onehot('0);
            out_valid_d = 1'b1;
            tmr_en      = 1'b1;
            tmr_load    = 1'b1;
          end else if (in_valid) begin
            idx_d       = in_sel;
            y_d         = onehot(in_sel);
            out_valid_d = 1'b1;
          end
        end
        ST_SCAN: begin
          if (mode == MODE_DECODE) begin
            state_d = ST_DEC;
          end else begin
            out_valid_d = 1'b1;
            tmr_en      = 1'b1;
            if (tmr_zero) begin
              tmr_load = 1'b1;
              idx_d    = idx_q + 1'b1;
              y_d      = onehot(idx_q + 1'b1);
              wrap_d   = (idx_q == {N{1'b1}});
            end
          end
        end
        default: state_d = ST_DEC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_DEC;
      y_q         <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      wrap_q      <= wrap_d;
    end
  end

  dwell_timer #(.DWELL_W(DWELL_W)) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .en       (tmr_en),
    .load     (tmr_load),
    .load_val (dwell),
    .zero     (tmr_zero)
  );

  assign Y         = y_q;
  assign idx       = idx_q;
  assign out_valid = out_valid_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_decoder_scan_n.sv
// Bench for decoder_scan_n (N=3, DWELL_W=4): decode table, directed scan
// corner cases, then random traffic against a cycle-level reference model.
module tb_decoder_scan_n;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in_sel = '0;
  logic [3:0] dwell = '0;
  logic [7:0] Y;
  logic [2:0] idx;
  logic       out_valid;
  logic       wrap;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  decoder_scan_n #(.N(3), .DWELL_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid),
    .in_sel(in_sel), .dwell(dwell), .Y(Y), .idx(idx),
    .out_valid(out_valid), .wrap(wrap)
  );

  // Reference model: scanning flag, presented index, cycles left on it.
  bit         m_scan;
  int         m_idx;
  int         m_left;
  logic [7:0] m_y;
  logic       m_ov, m_wrap;

  task automatic model_step(input logic r, e, md, v, input int s, d);
    m_ov = 1'b0;
    m_wrap = 1'b0;
    if (r) begin
      m_scan = 0; m_idx = 0; m_left = 0; m_y = 8'h00;
    end else if (e) begin
      if (!m_scan) begin
        if (md) begin
          m_scan = 1; m_idx = 0; m_y = 8'h01; m_left = d; m_ov = 1'b1;
        end else if (v) begin
          m_idx = s; m_y = 8'(1 << s); m_ov = 1'b1;
        end
      end else if (!md) begin
        m_scan = 0;
      end else begin
        m_ov = 1'b1;
        if (m_left > 0) m_left--;
        else begin
          m_wrap = (m_idx == 7);
          m_idx = (m_idx + 1) % 8;
          m_y = 8'(1 << m_idx);
          m_left = d;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // One clock: drive at negedge, step the model at the edge, compare after it.
  task automatic cyc(input logic r, e, md, v, input logic [2:0] s, input logic [3:0] d);
    @(negedge clk);
    rst = r; en = e; mode = md; in_valid = v; in_sel = s; dwell = d;
    @(posedge clk);
    model_step(r, e, md, v, int'(s), int'(d));
    #1;
    chk("model_Y", Y, m_y);
    chk("model_idx", {5'b0, idx}, 8'(m_idx));
    chk("model_out_valid", {7'b0, out_valid}, {7'b0, m_ov});
    chk("model_wrap", {7'b0, wrap}, {7'b0, m_wrap});
    total_cnt++;
    if ($countones(Y) <= 1) pass_cnt++;
    else $display("FAIL onehot: got Y=%0h required at most one bit", Y);
  endtask

  typedef struct {
    logic       v;
    logic [2:0] sel;
    logic [7:0] y;
    logic [2:0] ix;
    logic       ov;
  } vec_t;
  vec_t tbl[10];

  initial begin
    for (int i = 0; i < 8; i++) begin
      tbl[i].v = 1'b1; tbl[i].sel = 3'(i); tbl[i].ix = 3'(i); tbl[i].ov = 1'b1;
    end
    tbl[0].y = 8'h01; tbl[1].y = 8'h02; tbl[2].y = 8'h04; tbl[3].y = 8'h08;
    tbl[4].y = 8'h10; tbl[5].y = 8'h20; tbl[6].y = 8'h40; tbl[7].y = 8'h80;
    // in_valid low: outputs hold, out_valid drops
    tbl[8] = '{v: 1'b0, sel: 3'd2, y: 8'h80, ix: 3'd7, ov: 1'b0};
    tbl[9] = '{v: 1'b1, sel: 3'd3, y: 8'h08, ix: 3'd3, ov: 1'b1};

    // Reset state
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 3'd5, 0);
    chk("rst_Y", Y, 8'h00);
    chk("rst_idx", {5'b0, idx}, 8'h00);
    chk("rst_ov", {7'b0, out_valid}, 8'h00);

    // Decode sweep from table
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 0, tbl[i].v, tbl[i].sel, 0);
      chk("dec_Y", Y, tbl[i].y);
      chk("dec_idx", {5'b0, idx}, {5'b0, tbl[i].ix});
      chk("dec_ov", {7'b0, out_valid}, {7'b0, tbl[i].ov});
    end

    // Scan, dwell=0: idx 0..7,0,1 with wrap only on the second 0
    for (int k = 0; k < 10; k++) begin
      cyc(0, 1, 1, 0, 0, 0);
      chk("scan0_idx", {5'b0, idx}, 8'(k % 8));
      chk("scan0_Y", Y, 8'(1 << (k % 8)));
      chk("scan0_wrap", {7'b0, wrap}, (k == 8) ? 8'h01 : 8'h00);
    end
    cyc(0, 1, 0, 0, 0, 0);

    // Scan, dwell=2: each index held 3 cycles, wraps after 24
    for (int k = 0; k < 25; k++) begin
      cyc(0, 1, 1, 0, 0, 4'd2);
      chk("scan2_idx", {5'b0, idx}, 8'((k / 3) % 8));
      chk("scan2_wrap", {7'b0, wrap}, (k == 24) ? 8'h01 : 8'h00);
    end
    cyc(0, 1, 0, 0, 0, 0);

    // Collision then pause mid-dwell (dwell=1)
    cyc(0, 1, 1, 1, 3'd5, 4'd1);
    chk("coll_Y", Y, 8'h01);
    chk("coll_idx", {5'b0, idx}, 8'h00);
    cyc(0, 1, 1, 0, 0, 4'd1);
    cyc(0, 1, 1, 0, 0, 4'd1);
    chk("pre_pause_idx", {5'b0, idx}, 8'h01);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 1, 0, 0, 4'd1);
      chk("pause_Y", Y, 8'h02);
      chk("pause_ov", {7'b0, out_valid}, 8'h00);
    end
    cyc(0, 1, 1, 0, 0, 4'd1);
    chk("resume1_idx", {5'b0, idx}, 8'h01);
    cyc(0, 1, 1, 0, 0, 4'd1);
    chk("resume2_idx", {5'b0, idx}, 8'h02);
    cyc(0, 1, 0, 0, 0, 0);

    // Reset mid-scan at idx=6
    for (int k = 0; k < 7; k++) cyc(0, 1, 1, 0, 0, 0);
    chk("pre_rst_idx", {5'b0, idx}, 8'h06);
    cyc(1, 1, 1, 0, 0, 0);
    chk("midrst_Y", Y, 8'h00);
    chk("midrst_idx", {5'b0, idx}, 8'h00);
    chk("midrst_ov", {7'b0, out_valid}, 8'h00);
    cyc(0, 1, 0, 1, 3'd4, 0);
    chk("post_rst_dec_Y", Y, 8'h10);

    // Scan-to-decode return at idx=3
    for (int k = 0; k < 4; k++) cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("ret_Y", Y, 8'h08);
    chk("ret_ov", {7'b0, out_valid}, 8'h00);
    chk("ret_wrap", {7'b0, wrap}, 8'h00);
    cyc(0, 1, 0, 1, 3'd2, 0);
    chk("ret_dec_Y", Y, 8'h04);

    // Random traffic vs model
    begin
      logic rm = 1'b0;
      for (int k = 0; k < 3000; k++) begin
        if ($urandom_range(15) == 0) rm = ~rm;
        cyc(($urandom_range(99) == 0), ($urandom_range(7) != 0), rm,
            1'($urandom), 3'($urandom), 4'($urandom_range(3)));
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
